vreg_write_arbiter: RTL and testbench

Arbitrates the single vector-register-file write port between two requesters: the pipeline writeback path (vector result or vector load) and the convolution unit's result path. Pipeline writes always win. Conv writes are accepted into a small in-order FIFO and drained in cycles where the pipeline does not write. The block also reports pending-write hazards to decode and kills stale conv writes when a newer pipeline write targets the same register. It sits between the writeback stage and the vector register file.

---
 rtl/vreg_write_arbiter_pkg.sv | 21 ++
 rtl/conv_wr_fifo.sv | 84 ++++++++
 rtl/vreg_write_arbiter.sv | 120 ++++++++++++
 tb/tb_vreg_write_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/vreg_write_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vreg_write_arbiter_pkg : shared widths and write-source encoding
// Revision: 1.0
// ---------------------------------------------------------------------------
package vreg_write_arbiter_pkg;

  localparam int LENGTH  = 8;
  localparam int INT8    = 8;
  localparam int INT32   = 32;
  localparam int VREG_AW = 5;

  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,
    SRC_WB     = 2'd1,
    SRC_HEAD   = 2'd2,
    SRC_BYPASS = 2'd3
  } wr_src_e;

endpackage
`default_nettype wire

// File: rtl/conv_wr_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// conv_wr_fifo : in-order conv write queue with per-entry kill and hazard match
// Revision: 1.0
// ---------------------------------------------------------------------------
module conv_wr_fifo #(
  parameter int VW    = 64,
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          push_kill,
  input  logic [AW-1:0] push_addr,
  input  logic [VW-1:0] push_data,
  input  logic          pop,
  input  logic          kill_en,
  input  logic [AW-1:0] kill_addr,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic [PW:0]   count,
  output logic          head_valid,
  output logic [AW-1:0] head_addr,
  output logic [VW-1:0] head_data,
  output logic          match_a,
  output logic          match_b
);

  logic [AW-1:0]    r_addr [DEPTH];
  logic [VW-1:0]    r_data [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [PW:0]      r_count;
  logic [DEPTH-1:0] w_hit_a;
  logic [DEPTH-1:0] w_hit_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      // A newer pipeline write supersedes every queued write to its register.
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en && (r_addr[i] == kill_addr)) r_valid[i] <= 1'b0;
      end
      if (pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      if (push) begin
        r_addr[r_tail]  <= push_addr;
        r_data[r_tail]  <= push_data;
        r_valid[r_tail] <= !push_kill;
        r_tail          <= r_tail + 1'b1;
      end
      case ({push, pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  generate
    for (genvar g = 0; g < DEPTH; g++) begin : g_match
      assign w_hit_a[g] = r_valid[g] && (r_addr[g] == rd_addr_a);
      assign w_hit_b[g] = r_valid[g] && (r_addr[g] == rd_addr_b);
    end
  endgenerate

  assign count      = r_count;
  assign head_valid = (r_count != '0) && r_valid[r_head];
  assign head_addr  = r_addr[r_head];
  assign head_data  = r_data[r_head];
  assign match_a    = |w_hit_a;
  assign match_b    = |w_hit_b;

endmodule
`default_nettype wire

// File: rtl/vreg_write_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vreg_write_arbiter : vector RF write-port arbiter, pipeline over queued conv
// Revision: 1.0
// ---------------------------------------------------------------------------
module vreg_write_arbiter
  import vreg_write_arbiter_pkg::*;
#(
  parameter int VW    = LENGTH * INT8,
  parameter int DEPTH = 4,
  parameter int AW    = VREG_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_v_write,
  input  logic [AW-1:0] wb_rD,
  input  logic [VW-1:0] wb_vdata,
  input  logic          conv_write,
  input  logic [AW-1:0] conv_addr,
  input  logic [VW-1:0] conv_result,
  output logic          conv_ready,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic          pend_hit_a,
  output logic          pend_hit_b,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [VW-1:0] rf_wdata,
  output logic [15:0]   conv_drain_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] C_DEPTH = (PW+1)'(DEPTH);

  logic [PW:0]   w_count;
  logic          w_head_valid;
  logic [AW-1:0] w_head_addr;
  logic [VW-1:0] w_head_data;
  logic          w_match_a;
  logic          w_match_b;
  logic          w_accept;
  logic          w_pop;
  logic          w_push;
  logic          w_push_kill;
  wr_src_e       w_src;

  assign conv_ready = !rst && (w_count < C_DEPTH);
  assign w_accept   = conv_write && conv_ready;

  always_comb begin
    w_src = SRC_NONE;
    if (wb_v_write)                        w_src = SRC_WB;
    else if (w_head_valid)                 w_src = SRC_HEAD;
    else if ((w_count == '0) && w_accept)  w_src = SRC_BYPASS;
  end

  // Killed heads drain silently even while the pipeline owns the port.
  assign w_pop       = (w_count != '0) && (!w_head_valid || (w_src == SRC_HEAD));
  assign w_push      = w_accept && (w_src != SRC_BYPASS);
  assign w_push_kill = wb_v_write && (conv_addr == wb_rD);

  conv_wr_fifo #(
    .VW    (VW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (w_push),
    .push_kill  (w_push_kill),
    .push_addr  (conv_addr),
    .push_data  (conv_result),
    .pop        (w_pop),
    .kill_en    (wb_v_write),
    .kill_addr  (wb_rD),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .count      (w_count),
    .head_valid (w_head_valid),
    .head_addr  (w_head_addr),
    .head_data  (w_head_data),
    .match_a    (w_match_a),
    .match_b    (w_match_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we          <= 1'b0;
      rf_waddr       <= '0;
      rf_wdata       <= '0;
      conv_drain_cnt <= '0;
    end else begin
      case (w_src)
        SRC_WB: begin
          rf_we    <= 1'b1;
          rf_waddr <= wb_rD;
          rf_wdata <= wb_vdata;
        end
        SRC_HEAD: begin
          rf_we          <= 1'b1;
          rf_waddr       <= w_head_addr;
          rf_wdata       <= w_head_data;
          conv_drain_cnt <= conv_drain_cnt + 16'd1;
        end
        SRC_BYPASS: begin
          rf_we          <= 1'b1;
          rf_waddr       <= conv_addr;
          rf_wdata       <= conv_result;
          conv_drain_cnt <= conv_drain_cnt + 16'd1;
        end
        default: rf_we <= 1'b0;
      endcase
    end
  end

  assign pend_hit_a = w_match_a || (rf_we && (rf_waddr == rd_addr_a));
  assign pend_hit_b = w_match_b || (rf_we && (rf_waddr == rd_addr_b));

endmodule
`default_nettype wire

// File: tb/tb_vreg_write_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_vreg_write_arbiter : directed + random stimulus against a queue model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_vreg_write_arbiter;

  localparam int VW    = 64;
  localparam int DEPTH = 4;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_v_write;
  logic [AW-1:0] wb_rD;
  logic [VW-1:0] wb_vdata;
  logic          conv_write;
  logic [AW-1:0] conv_addr;
  logic [VW-1:0] conv_result;
  logic          conv_ready;
  logic [AW-1:0] rd_addr_a;
  logic [AW-1:0] rd_addr_b;
  logic          pend_hit_a;
  logic          pend_hit_b;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [VW-1:0] rf_wdata;
  logic [15:0]   conv_drain_cnt;

  vreg_write_arbiter #(.VW(VW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .wb_v_write     (wb_v_write),
    .wb_rD          (wb_rD),
    .wb_vdata       (wb_vdata),
    .conv_write     (conv_write),
    .conv_addr      (conv_addr),
    .conv_result    (conv_result),
    .conv_ready     (conv_ready),
    .rd_addr_a      (rd_addr_a),
    .rd_addr_b      (rd_addr_b),
    .pend_hit_a     (pend_hit_a),
    .pend_hit_b     (pend_hit_b),
    .rf_we          (rf_we),
    .rf_waddr       (rf_waddr),
    .rf_wdata       (rf_wdata),
    .conv_drain_cnt (conv_drain_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [VW-1:0] data;
    bit            valid;
  } ent_t;

  ent_t          q[$];
  bit            m_we;
  logic [AW-1:0] m_waddr;
  logic [VW-1:0] m_wdata;
  logic [15:0]   m_cnt;
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic check_value(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  // Queue-level view: one port winner per cycle, stale entries drop out of the queue.
  task automatic model_step();
    bit acc;
    bit byp;
    byp = 1'b0;
    if (rst) begin
      q.delete();
      m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_cnt = '0;
      return;
    end
    acc = conv_write && (q.size() < DEPTH);
    if (wb_v_write) begin
      m_we = 1'b1; m_waddr = wb_rD; m_wdata = wb_vdata;
    end else if (q.size() > 0 && q[0].valid) begin
      m_we = 1'b1; m_waddr = q[0].addr; m_wdata = q[0].data; m_cnt++;
    end else if (q.size() == 0 && acc) begin
      m_we = 1'b1; m_waddr = conv_addr; m_wdata = conv_result; m_cnt++; byp = 1'b1;
    end else begin
      m_we = 1'b0;
    end
    if (q.size() > 0 && (!wb_v_write || !q[0].valid)) void'(q.pop_front());
    if (wb_v_write) foreach (q[i]) if (q[i].addr == wb_rD) q[i].valid = 1'b0;
    if (acc && !byp) q.push_back('{conv_addr, conv_result, !(wb_v_write && conv_addr == wb_rD)});
  endtask

  function automatic bit model_pend(input logic [AW-1:0] a);
    bit h;
    h = m_we && (m_waddr == a);
    foreach (q[i]) if (q[i].valid && q[i].addr == a) h = 1'b1;
    return h;
  endfunction

  task automatic check_all();
    check_value("conv_ready", VW'(conv_ready), VW'(!rst && q.size() < DEPTH));
    check_value("pend_hit_a", VW'(pend_hit_a), VW'(model_pend(rd_addr_a)));
    check_value("pend_hit_b", VW'(pend_hit_b), VW'(model_pend(rd_addr_b)));
    check_value("rf_we", VW'(rf_we), VW'(m_we));
    if (m_we) begin
      check_value("rf_waddr", VW'(rf_waddr), VW'(m_waddr));
      check_value("rf_wdata", rf_wdata, m_wdata);
    end
    check_value("conv_drain_cnt", VW'(conv_drain_cnt), VW'(m_cnt));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input bit wb, input logic [AW-1:0] rd, input logic [VW-1:0] wd,
                       input bit cw, input logic [AW-1:0] ca, input logic [VW-1:0] cd);
    wb_v_write = wb; wb_rD = rd; wb_vdata = wd;
    conv_write = cw; conv_addr = ca; conv_result = cd;
  endtask

  task automatic idle(input int n);
    drive(0, '0, '0, 0, '0, '0);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [VW-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    int idx;
    rst = 1'b1; rd_addr_a = '0; rd_addr_b = '0;
    drive(0, '0, '0, 0, '0, '0);
    tick(); tick();
    check_value("reset_rf_we", VW'(rf_we), '0);
    check_value("reset_ready", VW'(conv_ready), '0);
    rst = 1'b0;
    #1;
    check_value("ready_after_reset", VW'(conv_ready), VW'(1));

    // Bypass from idle.
    drive(0, '0, '0, 1, 5'd3, {8{8'hAA}});
    tick();
    check_value("bypass_addr", VW'(rf_waddr), VW'(3));
    idle(1);
    check_value("bypass_drain", VW'(conv_drain_cnt), VW'(1));

    // Pipeline priority with conv backpressure.
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      drive(1, 5'd1, 64'h1111 + 64'(c), idx < 5, 5'(4 + idx), 64'hC000 + 64'(idx));
      if (idx < 5 && q.size() < DEPTH) idx++;
      tick();
    end
    check_value("full_ready", VW'(conv_ready), '0);
    idle(6);
    check_value("priority_drain", VW'(conv_drain_cnt), VW'(5));

    // Kill rule.
    drive(1, 5'd1, 64'h1, 1, 5'd9, 64'hDEAD_0009);
    tick();
    drive(1, 5'd9, 64'h9999, 0, '0, '0);
    tick();
    idle(3);

    // Same-cycle same-address conv and pipeline writes.
    drive(1, 5'd2, 64'h2222, 1, 5'd2, 64'hBAD2);
    tick();
    idle(3);
    check_value("same_addr_drain", VW'(conv_drain_cnt), VW'(5));

    // Hazard reporting.
    rd_addr_a = 5'd12; rd_addr_b = 5'd13;
    drive(1, 5'd1, 64'h1, 1, 5'd12, 64'hC12);
    tick();
    drive(1, 5'd1, 64'h1, 0, '0, '0);
    tick();
    check_value("hazard_a", VW'(pend_hit_a), VW'(1));
    check_value("hazard_b", VW'(pend_hit_b), VW'(0));
    idle(3);

    // Reset with three entries queued.
    for (int c = 0; c < 3; c++) begin
      drive(1, 5'd1, 64'h1, 1, 5'(20 + c), 64'hE0 + 64'(c));
      tick();
    end
    drive(0, '0, '0, 0, '0, '0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_value("ready_mid_reset", VW'(conv_ready), VW'(1));
    idle(4);
    check_value("no_write_after_reset", VW'(rf_we), '0);

    // Random traffic over a small address range to provoke kills and hazards.
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 99) < 2);
      rd_addr_a = 5'($urandom_range(0, 7));
      rd_addr_b = 5'($urandom_range(0, 7));
      drive($urandom_range(0, 99) < 45, 5'($urandom_range(0, 7)), rnd64(),
            $urandom_range(0, 99) < 55, 5'($urandom_range(0, 7)), rnd64());
      tick();
    end
    rst = 1'b0;
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
